// File: rtl/downsample_frame_arbiter_pkg.sv
// rtl/downsample_frame_arbiter_pkg.sv - shared state enum, source encodings and winner selection
package downsample_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Round-robin pick: the requester other than last wins if valid, otherwise fall back.
    function automatic logic pick_src(input logic last, input logic av, input logic bv);
        if (last == SRC_B)
            return av ? SRC_A : SRC_B;
        else
            return bv ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/downsample_frame_arbiter_raster_counter.sv
// rtl/downsample_frame_arbiter_raster_counter.sv - x/y raster position counter with line and frame end decode
module raster_counter #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          eol,
    output logic          eof
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    assign eol = (x == X_LAST);
    assign eof = eol && (y == Y_LAST);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (eol) begin
                x <= '0;
                y <= eof ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/downsample_frame_arbiter.sv
// rtl/downsample_frame_arbiter.sv - frame-granular round-robin arbiter feeding one downsampler stream
module downsample_frame_arbiter
    import downsample_frame_arbiter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              enable,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_eol,
    output logic              out_eof,
    input  logic              out_ready,
    output logic              frame_done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    state_t          state;
    logic            last_src;
    logic            cur_src;
    logic            xfer;
    logic            frame_end;
    logic            winner;
    logic            any_valid;
    logic            cnt_eol;
    logic            cnt_eof;
    logic [XW-1:0]   cnt_x;
    logic [YW-1:0]   cnt_y;
    logic            unused_xy;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .CLK   (CLK),
        .RESET (RESET),
        .adv   (xfer),
        .x     (cnt_x),
        .y     (cnt_y),
        .eol   (cnt_eol),
        .eof   (cnt_eof)
    );

    assign unused_xy = ^{cnt_x, cnt_y};

    // Forwarding path is purely combinational so a granted beat costs no latency.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_src   = SRC_A;
        out_eol   = 1'b0;
        out_eof   = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        unique case (state)
            GRANT_A: begin
                out_valid = a_valid;
                out_data  = a_data;
                out_src   = SRC_A;
                out_eol   = cnt_eol;
                out_eof   = cnt_eof;
                a_ready   = out_ready;
            end
            GRANT_B: begin
                out_valid = b_valid;
                out_data  = b_data;
                out_src   = SRC_B;
                out_eol   = cnt_eol;
                out_eof   = cnt_eof;
                b_ready   = out_ready;
            end
            default: ;
        endcase
    end

    assign cur_src   = (state == GRANT_B) ? SRC_B : SRC_A;
    assign xfer      = out_valid & out_ready;
    assign frame_end = xfer & out_eof;
    assign any_valid = a_valid | b_valid;
    // At frame end the priority already reflects the frame just finished.
    assign winner    = pick_src(frame_end ? cur_src : last_src, a_valid, b_valid);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            last_src   <= SRC_B;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable && any_valid)
                        state <= (winner == SRC_B) ? GRANT_B : GRANT_A;
                end
                GRANT_A, GRANT_B: begin
                    if (frame_end) begin
                        last_src   <= cur_src;
                        frame_done <= 1'b1;
                        if (enable && any_valid)
                            state <= (winner == SRC_B) ? GRANT_B : GRANT_A;
                        else
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_downsample_frame_arbiter.sv
// tb/tb_downsample_frame_arbiter.sv - scoreboard bench for the frame arbiter at WIDTH=4, HEIGHT=2
module tb_downsample_frame_arbiter;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int DW = 16;
    localparam int FB = W * H;

    typedef struct {
        logic          src;
        logic [DW-1:0] data;
        logic          eol;
        logic          eof;
    } beat_t;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          enable = 1'b1;
    logic          a_valid = 1'b0;
    logic [DW-1:0] a_data = 16'hA000;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [DW-1:0] b_data = 16'hB000;
    logic          b_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_src;
    logic          out_eol;
    logic          out_eof;
    logic          out_ready = 1'b1;
    logic          frame_done;

    int            n_tests = 0;
    int            n_fail = 0;
    beat_t         sb[$];
    int            a_cnt = 0;
    int            b_cnt = 0;
    int            beats = 0;
    logic          exp_fd = 1'b0;
    logic          held = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic          rand_ready = 1'b0;

    downsample_frame_arbiter #(
        .WIDTH  (W),
        .HEIGHT (H),
        .DATA_W (DW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .enable     (enable),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_beats(input logic src, input int first, input int n);
        beat_t e;
        for (int k = 0; k < n; k++) begin
            e.src  = src;
            e.data = (src ? 16'hB000 : 16'hA000) + DW'(first + k);
            e.eol  = ((k % W) == W - 1);
            e.eof  = ((k % FB) == FB - 1);
            sb.push_back(e);
        end
    endtask

    task automatic cycle();
        beat_t e;
        logic  xfer;
        logic  ax;
        logic  bx;
        @(negedge CLK);
        check("frame_done", frame_done, exp_fd);
        if (held && out_valid)
            check("stall_data", out_data, held_data);
        held = 1'b0;
        xfer = out_valid && out_ready;
        if (xfer) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("src", out_src, e.src);
                check("data", out_data, e.data);
                check("eol", out_eol, e.eol);
                check("eof", out_eof, e.eof);
                check("other_ready", e.src ? a_ready : b_ready, 0);
            end
            beats++;
        end
        if (out_valid && !out_ready) begin
            held      = 1'b1;
            held_data = out_data;
        end
        exp_fd = xfer && out_eof && RESET;
        ax = a_valid && a_ready;
        bx = b_valid && b_ready;
        @(posedge CLK);
        #1;
        if (ax) a_cnt++;
        if (bx) b_cnt++;
        a_data = 16'hA000 + DW'(a_cnt);
        b_data = 16'hB000 + DW'(b_cnt);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_beats(input int target, input int budget, output int used);
        int n0;
        n0   = beats;
        used = 0;
        while ((beats - n0) < target && used < budget) begin
            cycle();
            used++;
        end
        check("beat_count", beats - n0, target);
    endtask

    task automatic check_zero();
        check("rst_out_valid", out_valid, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        check("rst_eol_eof", {out_eol, out_eof}, 0);
        check("rst_frame_done", frame_done, 0);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        rand_ready = 1'b0;
        cycle();
        cycle();
        check_zero();
        check("sb_empty", sb.size(), 0);
        sb.delete();
        exp_fd = 1'b0;
        held = 1'b0;
        a_cnt = 0;
        b_cnt = 0;
        a_data = 16'hA000;
        b_data = 16'hB000;
        RESET = 1'b1;
    endtask

    initial begin
        int used;

        // A alone: one frame, one idle cycle of grant latency.
        do_reset();
        a_valid = 1'b1;
        push_beats(1'b0, 0, FB);
        run_beats(FB, 40, used);
        check("a_latency", used, FB + 1);
        a_valid = 1'b0;
        cycle();

        // Both valid: A, B, A back to back.
        do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        push_beats(1'b0, 0, FB);
        push_beats(1'b1, 0, FB);
        push_beats(1'b0, FB, FB);
        run_beats(3 * FB, 100, used);
        check("abab_no_bubble", used, 3 * FB + 1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        cycle();

        // B alone for two frames: same requester regranted with no gap.
        do_reset();
        b_valid = 1'b1;
        push_beats(1'b1, 0, 2 * FB);
        run_beats(2 * FB, 80, used);
        check("bb_no_bubble", used, 2 * FB + 1);
        b_valid = 1'b0;
        cycle();

        // Random backpressure.
        do_reset();
        a_valid = 1'b1;
        rand_ready = 1'b1;
        push_beats(1'b0, 0, FB);
        run_beats(FB, 300, used);
        a_valid = 1'b0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // enable dropped mid-frame: frame finishes, then IDLE until re-enabled.
        do_reset();
        a_valid = 1'b1;
        push_beats(1'b0, 0, FB);
        run_beats(3, 20, used);
        enable = 1'b0;
        run_beats(FB - 3, 20, used);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("dis_a_ready", a_ready, 0);
            check("dis_out_valid", out_valid, 0);
        end
        enable = 1'b1;
        push_beats(1'b0, FB, FB);
        run_beats(FB, 40, used);
        check("regrant_latency", used, FB + 1);
        a_valid = 1'b0;
        cycle();

        // Reset during beat 5 of a B frame.
        do_reset();
        b_valid = 1'b1;
        push_beats(1'b1, 0, 5);
        run_beats(4, 20, used);
        RESET = 1'b0;
        cycle();
        check("midrst_beats", sb.size(), 0);
        check_zero();
        a_valid = 1'b1;
        a_cnt = 0;
        b_cnt = 0;
        a_data = 16'hA000;
        b_data = 16'hB000;
        held = 1'b0;
        RESET = 1'b1;
        push_beats(1'b0, 0, FB);
        run_beats(FB, 40, used);
        check("post_rst_latency", used, FB + 1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        cycle();
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
